cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host-driven run controller for a small CPU core.
// It loads the instruction memory, starts, steps and pauses the CPU,
// stops at a breakpoint, and declares HALTED once the PC stops changing.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   host_valid/host_ready     command handshake (ready is low only while stepping)
//   host_cmd                  00 WRITE, 01 RUN, 10 STEP, 11 RESET
//   host_data                 WRITE payload
//   imem_we/addr/wdata        registered instruction-memory write port
//   cpu_rst, cpu_en           CPU reset (active high) and clock enable
//   pc_in                     CPU program counter
//   bp_en, bp_addr            breakpoint control
//   state_o                   IDLE=0 RUN=1 STEP=2 PAUSED=3 HALTED=4
//   cmd_err, step_done        one-cycle status pulses
//   run_cycles                saturating count of cpu_en-high cycles
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INSN_W      = 16,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned HALT_WINDOW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [1:0]        host_cmd,
  input  logic [INSN_W-1:0] host_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [2:0]        state_o,
  output logic              cmd_err,
  output logic              step_done,
  output logic [31:0]       run_cycles
);

  localparam int unsigned HcW = $clog2(HALT_WINDOW + 1);
  localparam int unsigned ScW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [HcW-1:0] HaltLast = HcW'(HALT_WINDOW - 1);
  localparam logic [ScW-1:0] StepLast = ScW'(STEP_CYCLES - 1);

  localparam logic [1:0] CmdWrite = 2'b00;
  localparam logic [1:0] CmdRun   = 2'b01;
  localparam logic [1:0] CmdStep  = 2'b10;
  localparam logic [1:0] CmdReset = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StPaused = 3'd3,
    StHalted = 3'd4
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] load_ptr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [HcW-1:0]    halt_cnt_q;
  logic [ScW-1:0]    step_cnt_q;

  logic accept;
  logic go_idle;
  logic cmd_bad;
  logic pc_changed;
  logic bp_hit;
  logic halt_hit;

  // Outputs decoded straight from the state register so that an asynchronous
  // reset drops cpu_en and raises cpu_rst without waiting for a clock edge.
  assign host_ready = (state_q != StStep);
  assign cpu_rst    = (state_q == StIdle);
  assign cpu_en     = (state_q == StRun) || (state_q == StStep);
  assign state_o    = state_q;

  always_comb begin
    accept     = host_valid & host_ready;
    go_idle    = accept && (host_cmd == CmdReset);
    pc_changed = (pc_in != pc_q);
    // Requiring a PC change lets a resume from the breakpoint address proceed.
    bp_hit     = bp_en && (pc_in == bp_addr) && pc_changed;
    halt_hit   = !pc_changed && (halt_cnt_q == HaltLast);
    cmd_bad    = 1'b0;
    unique case (state_q)
      StIdle:   cmd_bad = 1'b0;
      StRun:    cmd_bad = (host_cmd != CmdReset);
      StStep:   cmd_bad = 1'b0;
      StPaused: cmd_bad = (host_cmd == CmdWrite);
      StHalted: cmd_bad = (host_cmd != CmdReset);
      default:  cmd_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      load_ptr_q <= '0;
      pc_q       <= '0;
      halt_cnt_q <= '0;
      step_cnt_q <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cmd_err    <= 1'b0;
      step_done  <= 1'b0;
      run_cycles <= '0;
    end else begin
      imem_we   <= 1'b0;
      step_done <= 1'b0;
      cmd_err   <= accept & cmd_bad;
      pc_q      <= pc_in;

      if (cpu_en && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (host_cmd)
              CmdWrite: begin
                imem_we    <= 1'b1;
                imem_addr  <= load_ptr_q;
                imem_wdata <= host_data;
                load_ptr_q <= load_ptr_q + 1'b1;
              end
              CmdRun: begin
                state_q    <= StRun;
                halt_cnt_q <= '0;
              end
              CmdStep: begin
                state_q    <= StStep;
                step_cnt_q <= '0;
              end
              default: ;  // RESET handled by go_idle below
            endcase
          end
        end
        StRun: begin
          halt_cnt_q <= pc_changed ? '0 : halt_cnt_q + 1'b1;
          if (bp_hit) begin
            state_q <= StPaused;
          end else if (halt_hit) begin
            state_q <= StHalted;
          end
        end
        StStep: begin
          if (step_cnt_q == StepLast) begin
            state_q   <= StPaused;
            step_done <= 1'b1;
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        StPaused: begin
          if (accept && (host_cmd == CmdRun)) begin
            state_q    <= StRun;
            halt_cnt_q <= '0;
          end else if (accept && (host_cmd == CmdStep)) begin
            state_q    <= StStep;
            step_cnt_q <= '0;
          end
        end
        StHalted: ;
        default: state_q <= StIdle;
      endcase

      // An accepted RESET overrides everything above, including a breakpoint
      // hit or halt detect on the same edge.
      if (go_idle) begin
        state_q    <= StIdle;
        load_ptr_q <= '0;
        halt_cnt_q <= '0;
        step_cnt_q <= '0;
        run_cycles <= '0;
      end
    end
  end

endmodule
